// File: rtl/square_position_engine.sv
// rtl/square_position_engine.sv - per-frame position update and collision scan for 16 bouncing squares and a main square
module square_position_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SQUARE_SIZE = 30,
  parameter int SQ_STEP     = 2,
  parameter int MAIN_STEP   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refresh_tick,
  input  logic         pause,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  output logic [659:0] position,
  output logic         busy,
  output logic         collision,
  output logic [7:0]   hit_count
);

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SQUARE_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SQUARE_SIZE);
  localparam logic [10:0] S_M1   = 11'(SQUARE_SIZE - 1);
  localparam logic [10:0] S_STEP = 11'(SQ_STEP);
  localparam logic [10:0] M_STEP = 11'(MAIN_STEP);

  typedef enum logic [2:0] {IDLE, MAIN, SQ, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        coll_q, coll_d;
  logic        flag_q, flag_d;
  logic [7:0]  hit_q, hit_d;
  logic [9:0]  mx_q, mx_d, my_q, my_d;
  logic [9:0]  sx_q [16];
  logic [9:0]  sx_d [16];
  logic [9:0]  sy_q [16];
  logic [9:0]  sy_d [16];
  // direction bit 1 means the axis is moving toward 0
  logic [15:0] dx_q, dx_d, dy_q, dy_d;
  logic [10:0] bx, by;
  logic        ovl;

  // One bouncing-axis step: returns {flip, new_position}
  function automatic logic [10:0] bounce(input logic [9:0] p, input logic neg, input logic [10:0] maxv);
    logic [10:0] w;
    w = {1'b0, p};
    if (!neg) begin
      if (w + S_STEP > maxv) return {1'b1, maxv[9:0]};
      return {1'b0, 10'(w + S_STEP)};
    end
    if (w < S_STEP) return 11'h400;
    return {1'b0, 10'(w - S_STEP)};
  endfunction

  // Button-driven main-square axis move with clamping at 0 and maxv
  function automatic logic [9:0] main_move(input logic [9:0] p, input logic dec, input logic inc, input logic [10:0] maxv);
    logic [10:0] w;
    w = {1'b0, p};
    if (dec && !inc) w = (w >= M_STEP) ? w - M_STEP : 11'd0;
    else if (inc && !dec) w = (w + M_STEP > maxv) ? maxv : w + M_STEP;
    return w[9:0];
  endfunction

  // Next-state logic: sequencing, coordinate updates and collision accumulation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    coll_d  = coll_q;
    flag_d  = flag_q;
    hit_d   = hit_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    bx      = '0;
    by      = '0;
    ovl     = 1'b0;
    case (state_q)
      IDLE: begin
        if (refresh_tick && !pause) begin
          state_d = MAIN;
          busy_d  = 1'b1;
        end
      end
      MAIN: begin
        mx_d    = main_move(mx_q, btn_left, btn_right, X_MAX);
        my_d    = main_move(my_q, btn_up, btn_down, Y_MAX);
        idx_d   = 4'd0;
        state_d = SQ;
      end
      SQ: begin
        bx = bounce(sx_q[idx_q], dx_q[idx_q], X_MAX);
        by = bounce(sy_q[idx_q], dy_q[idx_q], Y_MAX);
        sx_d[idx_q] = bx[9:0];
        sy_d[idx_q] = by[9:0];
        dx_d[idx_q] = dx_q[idx_q] ^ bx[10];
        dy_d[idx_q] = dy_q[idx_q] ^ by[10];
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = SCAN;
      end
      SCAN: begin
        ovl = ({1'b0, sx_q[idx_q]} <= {1'b0, mx_q} + S_M1) &&
              ({1'b0, mx_q} <= {1'b0, sx_q[idx_q]} + S_M1) &&
              ({1'b0, sy_q[idx_q]} <= {1'b0, my_q} + S_M1) &&
              ({1'b0, my_q} <= {1'b0, sy_q[idx_q]} + S_M1);
        if (ovl) begin
          flag_d = 1'b1;
          if (hit_q != 8'hff) hit_d = hit_q + 8'd1;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        coll_d  = flag_q;
        flag_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and coordinate registers with asynchronous reset to the starting layout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      coll_q  <= 1'b0;
      flag_q  <= 1'b0;
      hit_q   <= '0;
      mx_q    <= 10'((SCREEN_W - SQUARE_SIZE) / 2);
      my_q    <= 10'((SCREEN_H - SQUARE_SIZE) / 2);
      dx_q    <= 16'haaaa;
      dy_q    <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        sx_q[i] <= 10'(40 * i + 5);
        sy_q[i] <= 10'(20 + 16 * i);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      coll_q  <= coll_d;
      flag_q  <= flag_d;
      hit_q   <= hit_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  // Bus packing: pure register view, padding bits tied low
  always_comb begin
    position = '0;
    for (int i = 0; i < 16; i++) begin
      position[i*40 +: 10]      = sx_q[i];
      position[i*40 + 10 +: 10] = sy_q[i];
    end
    position[640 +: 10] = mx_q;
    position[650 +: 10] = my_q;
  end

  assign busy      = busy_q;
  assign collision = coll_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_square_position_engine.sv
// tb/tb_square_position_engine.sv - self-checking bench for square_position_engine
module tb_square_position_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         refresh_tick = 1'b0;
  logic         pause = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [659:0] position;
  logic         busy, collision;
  logic [7:0]   hit_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // reference model state
  int msx[16], msy[16], mdx[16], mdy[16];
  int mmx, mmy, mhits;
  bit mcoll;

  square_position_engine dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .pause(pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .position(position), .busy(busy), .collision(collision), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  function automatic int sqx(int i); return int'(position[i*40 +: 10]); endfunction
  function automatic int sqy(int i); return int'(position[i*40+10 +: 10]); endfunction
  function automatic int mainx(); return int'(position[640 +: 10]); endfunction
  function automatic int mainy(); return int'(position[650 +: 10]); endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      msx[i] = 40 * i + 5; msy[i] = 20 + 16 * i;
      mdx[i] = (i % 2 == 0) ? 1 : -1; mdy[i] = 1;
    end
    mmx = 305; mmy = 225; mhits = 0; mcoll = 0;
  endtask

  task automatic bounce(inout int p, inout int d, input int mx);
    if (d > 0) begin
      if (p + 2 > mx) begin p = mx; d = -1; end else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; d = 1; end else p = p - 2;
    end
  endtask

  function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction

  task automatic model_frame(input bit up, input bit dn, input bit lf, input bit rt);
    int hits;
    if (lf && !rt) mmx = (mmx >= 4) ? mmx - 4 : 0;
    else if (rt && !lf) mmx = (mmx + 4 > 610) ? 610 : mmx + 4;
    if (up && !dn) mmy = (mmy >= 4) ? mmy - 4 : 0;
    else if (dn && !up) mmy = (mmy + 4 > 450) ? 450 : mmy + 4;
    for (int i = 0; i < 16; i++) begin
      bounce(msx[i], mdx[i], 610);
      bounce(msy[i], mdy[i], 450);
    end
    hits = 0;
    for (int i = 0; i < 16; i++)
      if (iabs(msx[i] - mmx) < 30 && iabs(msy[i] - mmy) < 30) hits++;
    mcoll = (hits > 0);
    mhits = (mhits + hits > 255) ? 255 : mhits + hits;
  endtask

  function automatic logic [659:0] exp_pos();
    logic [659:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      v[i*40 +: 10] = 10'(msx[i]);
      v[i*40+10 +: 10] = 10'(msy[i]);
    end
    v[640 +: 10] = 10'(mmx);
    v[650 +: 10] = 10'(mmy);
    return v;
  endfunction

  // Whenever no sequence is running, the DUT outputs must equal the model
  always begin
    @(posedge clk); #2;
    if (chk_en && !busy) begin
      n_tests++;
      if (position !== exp_pos() || collision !== mcoll || int'(hit_count) !== mhits) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t coll=%b exp=%b hits=%0d exp=%0d pos=%h exp=%h",
                 $time, collision, mcoll, hit_count, mhits, position, exp_pos());
      end
    end
  end

  task automatic frame(input bit up, input bit dn, input bit lf, input bit rt);
    int n;
    @(negedge clk);
    btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt;
    refresh_tick = 1'b1; pause = 1'b0;
    model_frame(up, dn, lf, rt);
    @(negedge clk);
    refresh_tick = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_len", n, 34);
  endtask

  task automatic do_reset();
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    bit lf, rt, up, dn;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_sq0_x", sqx(0), 5);     chk("rst_sq0_y", sqy(0), 20);
    chk("rst_sq15_x", sqx(15), 605); chk("rst_sq15_y", sqy(15), 260);
    chk("rst_main_x", mainx(), 305); chk("rst_main_y", mainy(), 225);
    chk("rst_busy", int'(busy), 0);  chk("rst_hits", int'(hit_count), 0);
    chk("rst_coll", int'(collision), 0);

    frame(0, 0, 0, 0);
    chk("t1_sq0_x", sqx(0), 7);   chk("t1_sq0_y", sqy(0), 22);
    chk("t1_sq1_x", sqx(1), 43);  chk("t1_sq1_y", sqy(1), 38);
    chk("t1_main_x", mainx(), 305); chk("t1_main_y", mainy(), 225);

    do_reset();
    repeat (22) frame(0, 0, 0, 0);
    chk("sq14_x_22", sqx(14), 609);
    frame(0, 0, 0, 0);
    chk("sq14_x_23", sqx(14), 610);
    frame(0, 0, 0, 0);
    chk("sq14_x_24", sqx(14), 608);

    do_reset();
    frame(1, 1, 1, 1);
    chk("both_btn_x", mainx(), 305); chk("both_btn_y", mainy(), 225);
    do_reset();
    repeat (76) frame(0, 0, 1, 0);
    chk("left_x_76", mainx(), 1);
    frame(0, 0, 1, 0);
    chk("left_x_77", mainx(), 0);
    frame(0, 0, 1, 0);
    chk("left_x_78", mainx(), 0);
    frame(0, 0, 1, 1);
    chk("left_both_x", mainx(), 0);

    // second tick while busy and a paused tick are both dropped
    do_reset();
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    refresh_tick = 1'b1;
    model_frame(0, 0, 0, 0);
    @(negedge clk); refresh_tick = 1'b0;
    repeat (9) @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("drop_busy_end", int'(busy), 0);
    pause = 1'b1; refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("pause_busy", int'(busy), 0);
    pause = 1'b0;
    chk("drop_sq0_x", sqx(0), 7); chk("drop_sq0_y", sqy(0), 22);

    // free run with a varied button pattern
    do_reset();
    for (int f = 0; f < 300; f++) begin
      lf = (f % 40) < 15;
      rt = ((f % 40) >= 20 && (f % 40) < 35) || (f % 7 == 0);
      up = (f % 50) < 20;
      dn = ((f % 50) >= 25 && (f % 50) < 45) || (f % 11 == 0);
      frame(up, dn, lf, rt);
    end
    chk("run_hits", int'(hit_count), mhits);

    // reset asserted in the middle of the scan phase
    chk_en = 0;
    @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (20) @(negedge clk);
    chk("midscan_busy_pre", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midscan_busy", int'(busy), 0);
    chk("midscan_sq0_x", sqx(0), 5);   chk("midscan_sq15_y", sqy(15), 260);
    chk("midscan_main_x", mainx(), 305); chk("midscan_main_y", mainy(), 225);
    chk("midscan_hits", int'(hit_count), 0); chk("midscan_coll", int'(collision), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1;
    frame(0, 0, 0, 0);
    chk("post_rst_sq0_x", sqx(0), 7);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
